control_bcd2bin: RTL and testbench

Sequencer and arbiter for the shared BCD-to-binary conversion datapath of the calculator. Two requesters share one converter: operand A entry and operand B entry. The block grants one requester at a time and drives the datapath through load, then alternating shift and correct steps, for a fixed iteration count. It signals completion to the granted requester with a one-cycle acknowledge. The iteration count is held inside this block, so the datapath needs no counter of its own.

---
 rtl/control_bcd2bin_if.sv | 22 ++
 rtl/control_bcd2bin.sv | 113 +++++++++++
 tb/tb_control_bcd2bin.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_bcd2bin_if.sv
// Handshake and datapath-control bundle between the requesters and the BCD-to-binary sequencer.
interface control_bcd2bin_if;
  logic sol_a;
  logic sol_b;
  logic sel_operando;
  logic carga;
  logic desplazar;
  logic corregir;
  logic ack_a;
  logic ack_b;
  logic ocupado;

  modport master (
    output sol_a, sol_b,
    input  sel_operando, carga, desplazar, corregir, ack_a, ack_b, ocupado
  );

  modport slave (
    input  sol_a, sol_b,
    output sel_operando, carga, desplazar, corregir, ack_a, ack_b, ocupado
  );
endinterface

// File: rtl/control_bcd2bin.sv
// Arbiter and sequencer for the shared BCD-to-binary converter:
// grants A or B, then drives load, N_ITER shifts interleaved with N_ITER-1 corrections, and an ack.
module control_bcd2bin #(
  parameter int unsigned N_ITER = 16,
  parameter int unsigned CW     = 5
) (
  input  logic              reloj,
  input  logic              reset,
  control_bcd2bin_if.slave  bus
);

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    CARGA    = 3'd1,
    DESPLAZA = 3'd2,
    CORRIGE  = 3'd3,
    FIN      = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_ptr_b, w_ptr_b_nxt;
  logic          r_sel, w_sel_nxt;

  logic r_carga, r_desplazar, r_corregir, r_ack_a, r_ack_b, r_ocupado;
  logic w_carga, w_desplazar, w_corregir, w_ack_a, w_ack_b, w_ocupado;

  // Next state, arbitration and iteration counter; strobes are decoded from the next state
  // so that the registered outputs match a Moore decode of the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_b_nxt = r_ptr_b;
    w_sel_nxt   = r_sel;

    case (r_state)
      REPOSO: begin
        if (bus.sol_a && (!bus.sol_b || !r_ptr_b)) begin
          w_sel_nxt   = 1'b0;
          w_state_nxt = CARGA;
        end else if (bus.sol_b) begin
          w_sel_nxt   = 1'b1;
          w_state_nxt = CARGA;
        end
      end
      CARGA: begin
        w_cnt_nxt   = CW'(N_ITER);
        w_state_nxt = DESPLAZA;
      end
      DESPLAZA: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = CORRIGE;
        end
      end
      CORRIGE: begin
        w_state_nxt = DESPLAZA;
      end
      FIN: begin
        w_ptr_b_nxt = ~r_sel;
        w_state_nxt = REPOSO;
      end
      default: begin
        w_state_nxt = REPOSO;
      end
    endcase

    w_carga     = (w_state_nxt == CARGA);
    w_desplazar = (w_state_nxt == DESPLAZA);
    w_corregir  = (w_state_nxt == CORRIGE);
    w_ack_a     = (w_state_nxt == FIN) && !w_sel_nxt;
    w_ack_b     = (w_state_nxt == FIN) && w_sel_nxt;
    w_ocupado   = (w_state_nxt != REPOSO);
  end

  // State, counter, pointer and output registers; everything moves on the falling edge.
  always_ff @(negedge reloj) begin
    if (reset) begin
      r_state     <= REPOSO;
      r_cnt       <= '0;
      r_ptr_b     <= 1'b0;
      r_sel       <= 1'b0;
      r_carga     <= 1'b0;
      r_desplazar <= 1'b0;
      r_corregir  <= 1'b0;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_ocupado   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ptr_b     <= w_ptr_b_nxt;
      r_sel       <= w_sel_nxt;
      r_carga     <= w_carga;
      r_desplazar <= w_desplazar;
      r_corregir  <= w_corregir;
      r_ack_a     <= w_ack_a;
      r_ack_b     <= w_ack_b;
      r_ocupado   <= w_ocupado;
    end
  end

  assign bus.sel_operando = r_sel;
  assign bus.carga        = r_carga;
  assign bus.desplazar    = r_desplazar;
  assign bus.corregir     = r_corregir;
  assign bus.ack_a        = r_ack_a;
  assign bus.ack_b        = r_ack_b;
  assign bus.ocupado      = r_ocupado;

endmodule

// File: tb/tb_control_bcd2bin.sv
// Directed bench for control_bcd2bin: default N_ITER=16 instance plus an N_ITER=4 instance.
module tb_control_bcd2bin;

  logic reloj;
  logic rst16;
  logic rst4;
  int   errors;
  int   checks;

  // Trace bits: [6]=sel [5]=carga [4]=desplazar [3]=corregir [2]=ack_a [1]=ack_b [0]=ocupado
  logic [6:0] tr [0:199];

  control_bcd2bin_if bus16 ();
  control_bcd2bin_if bus4 ();

  control_bcd2bin #(.N_ITER(16), .CW(5)) dut16 (.reloj(reloj), .reset(rst16), .bus(bus16.slave));
  control_bcd2bin #(.N_ITER(4),  .CW(5)) dut4  (.reloj(reloj), .reset(rst4),  .bus(bus4.slave));

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // Expected outputs in cycle k of a conversion whose carga cycle is k=1.
  function automatic logic [6:0] exp_vec(input int k, input int n, input bit b);
    logic c, d, r, aa, ab, o;
    c  = (k == 1);
    d  = (k >= 2) && (k <= 2*n) && (k % 2 == 0);
    r  = (k >= 3) && (k <= 2*n - 1) && (k % 2 == 1);
    aa = (k == 2*n + 1) && !b;
    ab = (k == 2*n + 1) && b;
    o  = (k >= 1) && (k <= 2*n + 1);
    return {b, c, d, r, aa, ab, o};
  endfunction

  // Samples n cycles on the non-active edge and behaves like the requesters (drop sol after ack).
  task automatic capture(input bit use4, input int n, input int drop_b_at);
    for (int k = 1; k <= n; k++) begin
      @(posedge reloj);
      if (use4) begin
        tr[k] = {bus4.sel_operando, bus4.carga, bus4.desplazar, bus4.corregir,
                 bus4.ack_a, bus4.ack_b, bus4.ocupado};
        if (bus4.ack_a) bus4.sol_a = 1'b0;
        if (bus4.ack_b) bus4.sol_b = 1'b0;
      end else begin
        tr[k] = {bus16.sel_operando, bus16.carga, bus16.desplazar, bus16.corregir,
                 bus16.ack_a, bus16.ack_b, bus16.ocupado};
        if (bus16.ack_a) bus16.sol_a = 1'b0;
        if (bus16.ack_b) bus16.sol_b = 1'b0;
        if (k == drop_b_at) bus16.sol_b = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [6:0] v16, v4;
    @(posedge reloj);
    rst16 = 1'b1;
    rst4  = 1'b1;
    repeat (2) @(posedge reloj);
    v16 = {bus16.sel_operando, bus16.carga, bus16.desplazar, bus16.corregir,
           bus16.ack_a, bus16.ack_b, bus16.ocupado};
    v4  = {bus4.sel_operando, bus4.carga, bus4.desplazar, bus4.corregir,
           bus4.ack_a, bus4.ack_b, bus4.ocupado};
    checks++;
    if (v16 !== 7'b0) begin errors++; $display("FAIL reset16 got=%b exp=%b", v16, 7'b0); end
    checks++;
    if (v4 !== 7'b0) begin errors++; $display("FAIL reset4 got=%b exp=%b", v4, 7'b0); end
    rst16 = 1'b0;
    rst4  = 1'b0;
  endtask

  task automatic test_single_a();
    int nd, nc, nab;
    logic [6:0] e;
    test_reset();
    bus16.sol_a = 1'b1;
    capture(1'b0, 40, 0);
    nd = 0; nc = 0; nab = 0;
    for (int k = 1; k <= 40; k++) begin
      e = (k <= 33) ? exp_vec(k, 16, 1'b0) : 7'b0;
      checks++;
      if (tr[k] !== e) begin errors++; $display("FAIL single_a k=%0d got=%b exp=%b", k, tr[k], e); end
      nd  += int'(tr[k][4]);
      nc  += int'(tr[k][3]);
      nab += int'(tr[k][1]);
    end
    checks++;
    if (nd !== 16) begin errors++; $display("FAIL single_a_shifts got=%0d exp=16", nd); end
    checks++;
    if (nc !== 15) begin errors++; $display("FAIL single_a_corrs got=%0d exp=15", nc); end
    checks++;
    if (nab !== 0) begin errors++; $display("FAIL single_a_ackb got=%0d exp=0", nab); end
  endtask

  task automatic test_both();
    int ia, ib;
    logic [6:0] e;
    test_reset();
    bus16.sol_a = 1'b1;
    bus16.sol_b = 1'b1;
    capture(1'b0, 75, 0);
    ia = 0; ib = 0;
    for (int k = 1; k <= 75; k++) begin
      if (k <= 33)      e = exp_vec(k, 16, 1'b0);
      else if (k == 34) e = 7'b0;
      else if (k <= 67) e = exp_vec(k - 34, 16, 1'b1);
      else              e = 7'b1000000;
      checks++;
      if (tr[k] !== e) begin errors++; $display("FAIL both k=%0d got=%b exp=%b", k, tr[k], e); end
      if (tr[k][2] && ia == 0) ia = k;
      if (tr[k][1] && ib == 0) ib = k;
    end
    checks++;
    if (ib - ia !== 34) begin errors++; $display("FAIL both_ack_gap got=%0d exp=34", ib - ia); end
  endtask

  task automatic test_priority();
    logic [6:0] e;
    // A alone moves the pointer to B
    bus16.sol_a = 1'b1;
    capture(1'b0, 34, 0);
    checks++;
    if (tr[33][2] !== 1'b1) begin errors++; $display("FAIL prio_pre_acka got=%b exp=1", tr[33][2]); end
    bus16.sol_a = 1'b1;
    bus16.sol_b = 1'b1;
    capture(1'b0, 70, 0);
    for (int k = 1; k <= 70; k++) begin
      if (k <= 33)      e = exp_vec(k, 16, 1'b1);
      else if (k == 34) e = 7'b1000000;
      else if (k <= 67) e = exp_vec(k - 34, 16, 1'b0);
      else              e = 7'b0;
      checks++;
      if (tr[k] !== e) begin errors++; $display("FAIL prio k=%0d got=%b exp=%b", k, tr[k], e); end
    end
    // A's FIN pointed back at B
    bus16.sol_a = 1'b1;
    bus16.sol_b = 1'b1;
    capture(1'b0, 70, 0);
    checks++;
    if (tr[1] !== exp_vec(1, 16, 1'b1)) begin errors++; $display("FAIL prio2_first got=%b exp=%b", tr[1], exp_vec(1, 16, 1'b1)); end
    checks++;
    if (tr[33] !== exp_vec(33, 16, 1'b1)) begin errors++; $display("FAIL prio2_ackb got=%b exp=%b", tr[33], exp_vec(33, 16, 1'b1)); end
    checks++;
    if (tr[67] !== exp_vec(33, 16, 1'b0)) begin errors++; $display("FAIL prio2_acka got=%b exp=%b", tr[67], exp_vec(33, 16, 1'b0)); end
  endtask

  task automatic test_drop_b();
    logic [6:0] e;
    bus16.sol_b = 1'b1;
    capture(1'b0, 40, 10);
    for (int k = 1; k <= 40; k++) begin
      e = (k <= 33) ? exp_vec(k, 16, 1'b1) : 7'b1000000;
      checks++;
      if (tr[k] !== e) begin errors++; $display("FAIL drop_b k=%0d got=%b exp=%b", k, tr[k], e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] v, e;
    int nack;
    // leave the pointer at B so that the reset's return to A is visible in arbitration
    bus16.sol_a = 1'b1;
    capture(1'b0, 34, 0);
    bus16.sol_a = 1'b1;
    capture(1'b0, 20, 0);
    nack = int'(tr[20][2]) + int'(tr[20][1]);
    rst16 = 1'b1;
    @(posedge reloj);
    v = {bus16.sel_operando, bus16.carga, bus16.desplazar, bus16.corregir,
         bus16.ack_a, bus16.ack_b, bus16.ocupado};
    checks++;
    if (v !== 7'b0) begin errors++; $display("FAIL reset_mid_idle got=%b exp=%b", v, 7'b0); end
    rst16 = 1'b0;
    bus16.sol_b = 1'b1;
    capture(1'b0, 35, 0);
    for (int k = 1; k <= 35; k++) begin
      if (k <= 33)      e = exp_vec(k, 16, 1'b0);
      else if (k == 34) e = 7'b0;
      else              e = exp_vec(1, 16, 1'b1);
      checks++;
      if (tr[k] !== e) begin errors++; $display("FAIL reset_mid k=%0d got=%b exp=%b", k, tr[k], e); end
    end
    checks++;
    if (nack !== 0) begin errors++; $display("FAIL reset_mid_noack got=%0d exp=0", nack); end
    capture(1'b0, 33, 0);
    checks++;
    if (tr[32][1] !== 1'b1) begin errors++; $display("FAIL reset_mid_drain_ackb got=%b exp=1", tr[32][1]); end
  endtask

  task automatic test_n4();
    logic [6:0] e;
    int nbusy;
    bus4.sol_a = 1'b1;
    capture(1'b1, 12, 0);
    nbusy = 0;
    for (int k = 1; k <= 12; k++) begin
      e = (k <= 9) ? exp_vec(k, 4, 1'b0) : 7'b0;
      checks++;
      if (tr[k] !== e) begin errors++; $display("FAIL n4 k=%0d got=%b exp=%b", k, tr[k], e); end
      nbusy += int'(tr[k][0]);
    end
    checks++;
    if (nbusy !== 9) begin errors++; $display("FAIL n4_busy got=%0d exp=9", nbusy); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst16 = 1'b1;
    rst4  = 1'b1;
    bus16.sol_a = 1'b0;
    bus16.sol_b = 1'b0;
    bus4.sol_a  = 1'b0;
    bus4.sol_b  = 1'b0;
    test_reset();
    test_single_a();
    test_both();
    test_priority();
    test_drop_b();
    test_reset_mid();
    test_n4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
